// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter
// Shares a single downstream cacheline memory port between the instruction
// cache (read-only) and the data cache (read/write). Whole-line transactions
// are serialised. The data cache has fixed priority. A streak cap limits how
// many data cache grants in a row can pass a waiting instruction fetch.
//
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   i_addr, i_read   icache line request (held until i_resp)
//   i_rdata, i_resp  line data and 1-cycle completion strobe to the icache
//   d_addr, d_read,  dcache line request, read or writeback
//   d_write, d_wdata (held until d_resp)
//   d_rdata, d_resp  line data and 1-cycle completion strobe to the dcache
//   mem_*            downstream port; mem_resp is a 1-cycle completion pulse
//
// Optional feature: define CACHELINE_ARB_PERF_EN to add three 32-bit
// performance counters: perf_i_grants, perf_d_grants and perf_i_wait.
module cacheline_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 256,
    parameter int MAX_DSTREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_read,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
`ifdef CACHELINE_ARB_PERF_EN
    ,
    output logic [31:0]           perf_i_grants,
    output logic [31:0]           perf_d_grants,
    output logic [31:0]           perf_i_wait
`endif
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    state_e                  state_q;
    logic [SW-1:0]           streak_q;
    logic [SW-1:0]           streak_d;
    logic [ADDR_WIDTH-1:0]   memAddr_q;
    logic                    memRead_q;
    logic                    memWrite_q;
    logic [LINE_WIDTH-1:0]   memWdata_q;
    logic                    dReq;
    logic                    grantI;
    logic                    grantD;

    // Grant decision taken in IDLE. The dcache wins unless the icache is
    // waiting and the dcache has already used up its streak allowance.
    always_comb begin
        dReq     = d_read | d_write;
        grantI   = 1'b0;
        grantD   = 1'b0;
        streak_d = streak_q;
        if (state_q == IDLE) begin
            if (dReq && (!i_read || (streak_q < STREAK_MAX))) begin
                grantD   = 1'b1;
                // streak_q < STREAK_MAX whenever i_read is set here, so the
                // increment cannot pass the cap.
                streak_d = i_read ? streak_q + 1'b1 : '0;
            end else if (i_read) begin
                grantI   = 1'b1;
                streak_d = '0;
            end
        end
    end

    // Main FSM. The downstream address, op and write data are latched at
    // grant so a requester that drops its request mid-transaction cannot
    // disturb the in-flight memory access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            streak_q   <= '0;
            memAddr_q  <= '0;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            memWdata_q <= '0;
        end else begin
            streak_q <= streak_d;
            case (state_q)
                IDLE: begin
                    if (grantD) begin
                        state_q    <= BUSY_D;
                        memAddr_q  <= d_addr;
                        // A simultaneous read and write is treated as a write.
                        memRead_q  <= ~d_write;
                        memWrite_q <= d_write;
                        memWdata_q <= d_wdata;
                    end else if (grantI) begin
                        state_q    <= BUSY_I;
                        memAddr_q  <= i_addr;
                        memRead_q  <= 1'b1;
                        memWrite_q <= 1'b0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_resp) begin
                        state_q    <= IDLE;
                        memRead_q  <= 1'b0;
                        memWrite_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    memRead_q  <= 1'b0;
                    memWrite_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = memAddr_q;
    assign mem_read  = memRead_q;
    assign mem_write = memWrite_q;
    assign mem_wdata = memWdata_q;

    // Only the completion strobe is steered; read data goes to both caches.
    assign i_resp  = (state_q == BUSY_I) && mem_resp;
    assign d_resp  = (state_q == BUSY_D) && mem_resp;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    // Illegal input combinations: both dcache ops at once, or a stray
    // downstream completion while nothing is outstanding.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(d_read && d_write));
            assert (!(mem_resp && (state_q == IDLE)));
        end
    end

`ifdef CACHELINE_ARB_PERF_EN
    // Performance counters; they wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_i_grants <= '0;
            perf_d_grants <= '0;
            perf_i_wait   <= '0;
        end else begin
            if (grantI) begin
                perf_i_grants <= perf_i_grants + 32'd1;
            end
            if (grantD) begin
                perf_d_grants <= perf_d_grants + 32'd1;
            end
            if (i_read && (state_q != BUSY_I)) begin
                perf_i_wait <= perf_i_wait + 32'd1;
            end
        end
    end
`endif

endmodule
